// File: rtl/obi_sram_responder.sv
// rtl/obi_sram_responder.sv - req/gnt/rvalid SRAM responder with programmable wait states and fixed response latency
module obi_sram_responder #(
   parameter int unsigned MEM_WORDS    = 4096,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned WAIT_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
   localparam logic [2:0]  WAIT_TGT  = 3'(WAIT_CYCLES);

   logic [2:0]              wcnt;
   logic [31:0]             offset;
   logic                    in_range;
   logic [IDX_W-1:0]        widx;
   logic [31:0]             mem [MEM_WORDS];
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_err;
   logic [31:0]             pipe_data [READ_LATENCY];

   // Grant is combinational from req so a zero-wait port can accept every cycle.
   assign data_gnt_o = data_req_i & (wcnt == WAIT_TGT) & ~rst;

   // Addresses below the base wrap to huge offsets, so both bounds are checked explicitly.
   assign offset   = data_addr_i - BASE_ADDR;
   assign in_range = (data_addr_i >= BASE_ADDR) && (offset < MEM_BYTES);
   assign widx     = offset[IDX_W+1:2];

   // Count cycles a request has been waiting; a grant or a withdrawn request restarts the count.
   always_ff @(posedge clk) begin
      if (rst || !data_req_i || data_gnt_o) begin
         wcnt <= 3'd0;
      end else begin
         wcnt <= wcnt + 3'd1;
      end
   end

   // Byte-masked RAM write at the end of the grant cycle; contents survive reset.
   always_ff @(posedge clk) begin
      if (data_gnt_o && data_we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Response shift register: stage 0 captures the grant-cycle result, last stage drives the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= data_gnt_o;
         pipe_err[0]   <= data_gnt_o & ~in_range;
         pipe_data[0]  <= (data_gnt_o && !data_we_i && in_range) ? mem[widx] : 32'h0;
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign data_rvalid_o = pipe_valid[READ_LATENCY-1];
   assign data_err_o    = pipe_err[READ_LATENCY-1];
   assign data_rdata_o  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_obi_sram_responder.sv
// tb/tb_obi_sram_responder.sv - scoreboard bench for obi_sram_responder in three parameter sets
module tb_obi_sram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_req, a_we, a_gnt, a_rvalid, a_err;
   logic [3:0]  a_be;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_req, b_we, b_gnt, b_rvalid, b_err;
   logic [3:0]  b_be;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        c_gnt, c_rvalid, c_err;
   logic [31:0] c_rdata;

   // a: zero wait, latency 1
   obi_sram_responder #(.MEM_WORDS(4096), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(1), .WAIT_CYCLES(0)) u_a (
      .clk(clk), .rst(rst), .data_req_i(a_req), .data_gnt_o(a_gnt), .data_we_i(a_we),
      .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
      .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata), .data_err_o(a_err));

   // b: two wait states, latency 3, small RAM at a non-zero base
   obi_sram_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0001_0000), .READ_LATENCY(3), .WAIT_CYCLES(2)) u_b (
      .clk(clk), .rst(rst), .data_req_i(b_req), .data_gnt_o(b_gnt), .data_we_i(b_we),
      .data_be_i(b_be), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
      .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata), .data_err_o(b_err));

   // c: shares a's request bus, zero wait, latency 3
   obi_sram_responder #(.MEM_WORDS(4096), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(3), .WAIT_CYCLES(0)) u_c (
      .clk(clk), .rst(rst), .data_req_i(a_req), .data_gnt_o(c_gnt), .data_we_i(a_we),
      .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
      .data_rvalid_o(c_rvalid), .data_rdata_o(c_rdata), .data_err_o(c_err));

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t       exp_q [3][$];
   logic [31:0] ram_model [3][int];
   logic [31:0] base_k [3] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
   int          words_k [3] = '{4096, 16, 4096};
   int          lat_k [3] = '{1, 3, 3};
   string       nm [3] = '{"a", "b", "c"};

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Scoreboard: pop and compare any response, then model any grant seen this cycle.
   always @(negedge clk) begin : monitor
      logic        g, v, e, we;
      logic [31:0] d, addr, wd, off, word;
      logic [3:0]  be;
      int          idx;
      resp_t       r;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin g = a_gnt; v = a_rvalid; e = a_err; d = a_rdata; end
            1:       begin g = b_gnt; v = b_rvalid; e = b_err; d = b_rdata; end
            default: begin g = c_gnt; v = c_rvalid; e = c_err; d = c_rdata; end
         endcase
         if (k == 1) begin
            we = b_we; be = b_be; addr = b_addr; wd = b_wdata;
         end else begin
            we = a_we; be = a_be; addr = a_addr; wd = a_wdata;
         end
         if (v) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("%s_unexpected_rvalid", nm[k]), {31'h0, v}, 32'h0);
            end else begin
               r = exp_q[k].pop_front();
               check($sformatf("%s_resp_cycle", nm[k]), cyc, r.due);
               check($sformatf("%s_resp_err", nm[k]), {31'h0, e}, {31'h0, r.err});
               check($sformatf("%s_resp_rdata", nm[k]), d, r.data);
            end
         end else begin
            check($sformatf("%s_idle_rdata", nm[k]), d, 32'h0);
            check($sformatf("%s_idle_err", nm[k]), {31'h0, e}, 32'h0);
         end
         if (rst) begin
            exp_q[k].delete();
         end else if (g) begin
            off    = addr - base_k[k];
            r.due  = cyc + lat_k[k];
            r.err  = 1'b1;
            r.data = 32'h0;
            if (addr >= base_k[k] && off < 32'(4 * words_k[k])) begin
               r.err = 1'b0;
               idx   = int'(off >> 2);
               word  = ram_model[k].exists(idx) ? ram_model[k][idx] : 32'h0;
               if (we) begin
                  for (int b = 0; b < 4; b++) begin
                     if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                  end
                  ram_model[k][idx] = word;
               end else begin
                  r.data = word;
               end
            end
            exp_q[k].push_back(r);
         end
      end
   end

   // Hold a request on bus s (0: a/c, 1: b) until granted; report wait cycles and grant cycle.
   task automatic req(input int s, input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output int waited, output int gcyc);
      if (s == 0) begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
      end else begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
      end
      waited = 0;
      gcyc   = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if ((s == 0) ? a_gnt : b_gnt) begin
            gcyc = cyc;
            break;
         end
         waited++;
      end
      if (gcyc < 0) check($sformatf("gnt_timeout_bus%0d", s), {31'h0, (s == 0) ? a_gnt : b_gnt}, 32'h1);
      @(posedge clk);
      #1;
      if (s == 0) a_req = 1'b0;
      else        b_req = 1'b0;
   endtask

   int w, g, gprev;

   initial begin
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 32'h0; a_wdata = 32'hCAFE_F00D;
      b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;

      repeat (3) begin
         @(negedge clk);
         check("rst_a_gnt", {31'h0, a_gnt}, 32'h0);
         check("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
         check("rst_a_rdata", a_rdata, 32'h0);
         check("rst_a_err", {31'h0, a_err}, 32'h0);
         check("rst_c_gnt", {31'h0, c_gnt}, 32'h0);
         check("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("first_gnt_after_rst", {31'h0, a_gnt}, 32'h1);
      @(posedge clk);
      #1;

      req(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, w, g);
      check("wr_gnt_same_cycle", w, 0);
      req(0, 1'b0, 32'h10, 4'hF, 32'h0, w, g);
      check("rd_gnt_same_cycle", w, 0);
      @(negedge clk);
      check("raw_rvalid", {31'h0, a_rvalid}, 32'h1);
      check("raw_rdata", a_rdata, 32'hDEAD_BEEF);
      check("raw_err", {31'h0, a_err}, 32'h0);

      @(posedge clk); #1;
      req(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, w, g);
      req(0, 1'b0, 32'h10, 4'hF, 32'h0, w, g);
      @(negedge clk);
      check("be0101_rdata", a_rdata, 32'hDE22_BE44);

      @(posedge clk); #1;
      req(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, w, g);
      req(0, 1'b0, 32'h10, 4'hF, 32'h0, w, g);
      @(negedge clk);
      check("be0000_rdata", a_rdata, 32'hDE22_BE44);

      @(posedge clk); #1;
      req(0, 1'b0, 32'h4000, 4'hF, 32'h0, w, g);
      @(negedge clk);
      check("oor_rd_err", {31'h0, a_err}, 32'h1);
      check("oor_rd_rdata", a_rdata, 32'h0);
      @(posedge clk); #1;
      req(0, 1'b1, 32'h4000, 4'hF, 32'h5555_5555, w, g);
      @(negedge clk);
      check("oor_wr_rvalid", {31'h0, a_rvalid}, 32'h1);
      check("oor_wr_err", {31'h0, a_err}, 32'h1);
      @(posedge clk); #1;
      req(0, 1'b0, 32'h0, 4'hF, 32'h0, w, g);
      @(negedge clk);
      check("addr0_unchanged", a_rdata, 32'hCAFE_F00D);

      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         req(1, 1'b1, 32'h0001_0000 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i) * 32'h0101_0101, w, g);
         check("b_wr_wait", w, 2);
      end
      gprev = -1;
      for (int i = 0; i < 4; i++) begin
         req(1, 1'b0, 32'h0001_0000 + 32'(4 * i), 4'hF, 32'h0, w, g);
         check("b_rd_wait", w, 2);
         if (i > 0) check("b_gnt_spacing", g - gprev, 3);
         gprev = g;
      end
      req(1, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0, w, g);
      req(1, 1'b1, 32'h0001_0040, 4'hF, 32'h7777_7777, w, g);
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("b_oor_rvalid", {31'h0, b_rvalid}, 32'h1);
      check("b_oor_err", {31'h0, b_err}, 32'h1);
      check("b_oor_rdata", b_rdata, 32'h0);

      @(posedge clk); #1;
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0001_0000; b_be = 4'hF; b_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("withdraw_no_gnt0", {31'h0, b_gnt}, 32'h0);
      @(posedge clk); #1 b_req = 1'b0;
      @(negedge clk);
      check("withdraw_no_gnt1", {31'h0, b_gnt}, 32'h0);
      @(posedge clk); #1;
      req(1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, w, g);
      check("withdraw_full_wait", w, 2);
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("withdraw_no_write", b_rdata, 32'hB000_0000);

      @(posedge clk); #1;
      req(0, 1'b0, 32'h10, 4'hF, 32'h0, w, g);
      req(0, 1'b0, 32'h0, 4'hF, 32'h0, w, g);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("postrst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      end
      @(posedge clk); #1;
      req(0, 1'b0, 32'h10, 4'hF, 32'h0, w, g);
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("postrst_c_rvalid_read", {31'h0, c_rvalid}, 32'h1);
      check("postrst_c_rdata", c_rdata, 32'hDE22_BE44);

      repeat (5) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_all_responses_seen", nm[k]), exp_q[k].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
